// File: rtl/alu_vec_pkg.sv
// Shared definitions for the vector ALU result path: serializer FSM states,
// the default lane width of the ALU array and a lowest-set-bit helper.
package alu_vec_pkg;

   // Result width of one ALU lane; the array and its consumers default to this.
   localparam int LANE_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } ser_state_t;

   // Index of the lowest set bit of v; 0 when v is all zeros.
   function automatic int lsb_index(input logic [31:0] v);
      lsb_index = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) lsb_index = i;
      end
   endfunction

endpackage

// File: rtl/vec_sync_fifo.sv
// Single-clock FIFO holding whole result vectors (data plus lane mask).
// Combinational read of the head entry; push is ignored when full and pop when empty.
module vec_sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge arst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Vector storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the count and pointers alone decide which entries are valid.
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_vec_result_serializer.sv
// Buffers result vectors from the ALU array and streams the enabled lanes,
// lowest lane first, one per accepted cycle on a byte-wide valid/ready interface.
module alu_vec_result_serializer
   import alu_vec_pkg::*;
#(
   parameter int N_LANE = 4,
   parameter int LANE_W = LANE_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_LANE*LANE_W-1:0]   in_data,
   input  logic [N_LANE-1:0]          in_mask,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANE_W-1:0]          out_data,
   output logic [$clog2(N_LANE)-1:0]  out_lane,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [7:0]                 drop_cnt
);

   localparam int IDX_W  = $clog2(N_LANE);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int DATA_W = N_LANE * LANE_W;
   localparam int ENT_W  = N_LANE * (LANE_W + 1);

   ser_state_t          state_q, state_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [N_LANE-1:0]   rem_mask_q, rem_mask_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;

   logic                fifo_push, fifo_pop;
   logic                fifo_full, fifo_empty;
   logic [ENT_W-1:0]    fifo_rdata;
   logic [DATA_W-1:0]   head_data;
   logic [N_LANE-1:0]   head_mask;

   logic [IDX_W-1:0]    lane_sel;
   logic [LANE_W-1:0]   lane_data;
   logic                single_bit;

   // Entry layout: {data, mask}; mask in the low bits.
   vec_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({in_data, in_mask}),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & in_ready;
   assign head_mask = fifo_rdata[N_LANE-1:0];
   assign head_data = fifo_rdata[ENT_W-1:N_LANE];
   assign drop_cnt  = drop_cnt_q;

   // Lane selector: lowest remaining lane and whether it is the final one of the vector.
   assign lane_sel   = IDX_W'(lsb_index(32'(rem_mask_q)));
   assign lane_data  = wdata_q[lane_sel*LANE_W +: LANE_W];
   assign single_bit = ((rem_mask_q & (rem_mask_q - N_LANE'(1))) == '0) && (rem_mask_q != '0);

   // Next-state, working-register updates and output decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      wdata_d    = wdata_q;
      rem_mask_d = rem_mask_q;
      drop_cnt_d = drop_cnt_q;
      fifo_pop   = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_lane   = '0;
      out_last   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end

         LOAD: begin
            if (fifo_empty) begin
               state_d = IDLE;
            end else begin
               fifo_pop   = 1'b1;
               wdata_d    = head_data;
               rem_mask_d = head_mask;
               if (head_mask == '0) begin
                  // All-zero vectors are discarded and counted, saturating.
                  if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                  state_d = ((fifo_count > CNT_W'(1)) || fifo_push) ? LOAD : IDLE;
               end else begin
                  state_d = SEND;
               end
            end
         end

         SEND: begin
            out_valid = 1'b1;
            out_data  = lane_data;
            out_lane  = lane_sel;
            out_last  = single_bit;
            if (out_ready) begin
               rem_mask_d = rem_mask_q & ~(N_LANE'(1) << lane_sel);
               if (single_bit) state_d = fifo_empty ? IDLE : LOAD;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // FSM state and working registers.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= IDLE;
         wdata_q    <= '0;
         rem_mask_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wdata_q    <= wdata_d;
         rem_mask_q <= rem_mask_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_vec_result_serializer.sv
// Randomized self-checking bench for alu_vec_result_serializer with a
// lane-list reference model and a negedge output monitor.
module tb_alu_vec_result_serializer;

   localparam int N_LANE = 4;
   localparam int LANE_W = 8;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        arst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_lane;
   logic        out_last;
   logic [2:0]  fifo_count;
   logic [7:0]  drop_cnt;

   typedef struct packed {
      logic [1:0] lane;
      logic [7:0] data;
      logic       last;
   } beat_t;

   beat_t exp_q[$];
   int    exp_drops = 0;
   int    n_pass    = 0;
   int    n_total   = 0;
   int    n_xfer    = 0;
   int    rdy_mode  = 0;   // 0 always ready, 1 never, 2 toggle, 3 random

   always #5 clk = ~clk;

   alu_vec_result_serializer #(
      .N_LANE (N_LANE),
      .LANE_W (LANE_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mask    (in_mask),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_lane   (out_lane),
      .out_last   (out_last),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model: a vector becomes the list of its enabled lanes in ascending order.
   task automatic model_push(input logic [31:0] d, input logic [3:0] m);
      int    lanes[$];
      beat_t b;
      for (int i = 0; i < N_LANE; i++) if (m[i]) lanes.push_back(i);
      if (lanes.size() == 0) begin
         if (exp_drops < 255) exp_drops++;
      end else begin
         for (int j = 0; j < lanes.size(); j++) begin
            b.lane = 2'(lanes[j]);
            b.data = d[lanes[j]*8 +: 8];
            b.last = (j == lanes.size() - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Offer one vector until accepted; called and returns 1 time unit after a rising edge.
   task automatic push_vec(input logic [31:0] d, input logic [3:0] m);
      bit acc = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
      for (int w = 0; w < 300 && !acc; w++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1;
            model_push(d, m);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("push_accept", 32'(acc), 1);
   endtask

   task automatic wait_drain();
      int c = 0;
      while ((exp_q.size() != 0 || fifo_count != 0 || out_valid) && c < 3000) begin
         @(posedge clk);
         #1;
         c++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("drain_left", exp_q.size(), 0);
      check("drain_fifo", 32'(fifo_count), 0);
      check("drop_cnt", 32'(drop_cnt), exp_drops);
   endtask

   // Consumer ready pattern.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: stream order, stall stability and zeroed idle outputs.
   initial begin
      bit          stall_q = 0;
      logic [11:0] stall_word = '0;
      logic [10:0] word;
      forever begin
         @(negedge clk);
         if (!arst) begin
            stall_q = 0;
         end else begin
            word = {out_lane, out_data, out_last};
            if (stall_q) check("stall_hold", {out_valid, word}, stall_word);
            if (out_valid && out_ready) begin
               n_xfer++;
               check("out_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) check("out_beat", word, exp_q.pop_front());
            end else if (!out_valid) begin
               check("idle_zero", word, 0);
            end
            stall_q    = out_valid && !out_ready;
            stall_word = {out_valid, word};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   lat;
      int   start;
      bit   got;
      arst     = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_mask  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_outs", {out_data, out_lane, out_last, fifo_count, drop_cnt}, 0);
      arst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full vector, latency from acceptance to first out_valid.
      push_vec(32'h44332211, 4'b1111);
      lat = -1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      check("latency", lat, 2);
      @(posedge clk);
      #1;
      wait_drain();

      // Sparse mask.
      push_vec(32'hDDCCBBAA, 4'b1010);
      wait_drain();

      // Dropped all-zero vector followed by a single-lane vector.
      push_vec(32'h12345678, 4'b0000);
      push_vec(32'h00000077, 4'b0001);
      wait_drain();
      check("drop_after_zero", 32'(drop_cnt), 1);

      // Fill with consumer stalled; one vector sits in the working regs, four in the FIFO.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      for (int v = 0; v < DEPTH + 1; v++) push_vec($urandom, 4'b1111);
      @(negedge clk);
      check("full_count", 32'(fifo_count), DEPTH);
      check("full_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 32'hCAFEF00D;
      in_mask  = 4'b1111;
      repeat (6) begin
         @(negedge clk);
         check("full_block", 32'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("full_hold_count", 32'(fifo_count), DEPTH);
      rdy_mode = 0;
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      check("ready_return", 32'(got), 1);
      check("ready_after_pop", 32'(fifo_count), DEPTH - 1);
      @(posedge clk);
      #1;
      wait_drain();

      // Backpressure: toggling, then random ready with random masks and gaps.
      for (int pass = 0; pass < 2; pass++) begin
         rdy_mode = 2 + pass;
         for (int v = 0; v < 16; v++) begin
            push_vec($urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         wait_drain();
      end

      // Reset after two of four lanes have been taken.
      rdy_mode = 0;
      @(posedge clk);
      #1;
      start = n_xfer;
      push_vec(32'h44332211, 4'b1111);
      for (int n = 0; n < 50 && n_xfer < start + 2; n++) @(posedge clk);
      check("pre_reset_xfers", n_xfer - start, 2);
      #1;
      arst = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_outs", {out_data, out_lane, out_last, fifo_count, drop_cnt}, 0);
      check("arst_in_ready", 32'(in_ready), 1);
      exp_q.delete();
      exp_drops = 0;
      repeat (3) @(posedge clk);
      #1;
      arst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("post_reset_quiet", {out_valid, fifo_count}, 0);
      end
      @(posedge clk);
      #1;
      push_vec($urandom, 4'($urandom_range(1, 15)));
      wait_drain();

      // Drop counter saturation.
      for (int v = 0; v < 260; v++) push_vec($urandom, 4'b0000);
      wait_drain();
      check("drop_saturate", 32'(drop_cnt), 255);
      push_vec(32'h5A6B7C8D, 4'b0110);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
